if_id_skid_buffer: RTL and testbench

- Two-entry skid buffer that forms the IF/ID pipeline register. It is the consumer end of the fetch stage's instruction/next_pc interface.
- It accepts {instruction, next_pc} from fetch with a valid/ready handshake and presents it to decode from registered outputs.
- It absorbs one cycle of decode back-pressure without a combinational ready path.
- A branch/jump redirect flush discards all buffered fetches and drives a NOP bubble.

---
 rtl/if_id_skid_buffer.sv | 116 +++++++++++
 tb/tb_if_id_skid_buffer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/if_id_skid_buffer.sv
// if_id_skid_buffer: two-entry IF/ID skid buffer with registered handshake and flush-to-NOP.
// Define IF_ID_FLUSH_STATS_EN to add the saturating flushed_count output.
module if_id_skid_buffer #(
   parameter int INSTR_W = 32,
   parameter int PC_W = 32,
   parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h00000020
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic [PC_W-1:0]    in_next_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [PC_W-1:0]    out_next_pc,
   input  logic               flush,
   output logic [1:0]         occupancy
`ifdef IF_ID_FLUSH_STATS_EN
   ,
   output logic [15:0]        flushed_count
`endif
);
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
   state_t state_q, state_d;
   logic in_ready_q, in_ready_d, out_valid_q, out_valid_d;
   logic [INSTR_W-1:0] main_instr_q, main_instr_d, skid_instr_q, skid_instr_d;
   logic [PC_W-1:0] main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
   logic push, pop;
   assign push = in_valid & in_ready_q;
   assign pop = out_valid_q & out_ready;
   always_comb begin
      state_d = state_q;
      main_instr_d = main_instr_q;
      main_pc_d = main_pc_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d = skid_pc_q;
      if (flush) begin
         state_d = EMPTY;
         main_instr_d = NOP_INSTR;
         main_pc_d = '0;
         skid_instr_d = '0;
         skid_pc_d = '0;
      end else begin
         case (state_q)
            EMPTY: if (push) begin
               state_d = ONE;
               main_instr_d = in_instr;
               main_pc_d = in_next_pc;
            end
            ONE: if (push && pop) begin
               main_instr_d = in_instr;
               main_pc_d = in_next_pc;
            end else if (push) begin
               state_d = FULL;
               skid_instr_d = in_instr;
               skid_pc_d = in_next_pc;
            end else if (pop) begin
               state_d = EMPTY;
               main_instr_d = NOP_INSTR;
               main_pc_d = '0;
            end
            FULL: if (pop) begin
               state_d = ONE;
               main_instr_d = skid_instr_q;
               main_pc_d = skid_pc_q;
               skid_instr_d = '0;
               skid_pc_d = '0;
            end
            default: state_d = EMPTY;
         endcase
      end
      in_ready_d = state_d != FULL;
      out_valid_d = state_d != EMPTY;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= EMPTY;
         in_ready_q <= 1'b1;
         out_valid_q <= 1'b0;
         main_instr_q <= NOP_INSTR;
         main_pc_q <= '0;
         skid_instr_q <= '0;
         skid_pc_q <= '0;
      end else begin
         state_q <= state_d;
         in_ready_q <= in_ready_d;
         out_valid_q <= out_valid_d;
         main_instr_q <= main_instr_d;
         main_pc_q <= main_pc_d;
         skid_instr_q <= skid_instr_d;
         skid_pc_q <= skid_pc_d;
      end
   end
   assign in_ready = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_instr = main_instr_q;
   assign out_next_pc = main_pc_q;
   assign occupancy = 2'(state_q);
`ifdef IF_ID_FLUSH_STATS_EN
   // Words lost to a flush: held entries not consumed this cycle plus a discarded push.
   logic [15:0] flushed_count_q, flushed_count_d;
   logic [1:0] flush_add;
   always_comb begin
      flush_add = occupancy - {1'b0, pop} + {1'b0, push};
      flushed_count_d = !flush ? flushed_count_q :
         (flushed_count_q > 16'hFFFF - 16'(flush_add)) ? 16'hFFFF : flushed_count_q + 16'(flush_add);
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) flushed_count_q <= '0;
      else flushed_count_q <= flushed_count_d;
   end
   assign flushed_count = flushed_count_q;
`endif
endmodule

// File: tb/tb_if_id_skid_buffer.sv
// tb_if_id_skid_buffer: directed self-checking bench for if_id_skid_buffer.
// Flush-statistics checks are compiled only when IF_ID_FLUSH_STATS_EN is defined.
module tb_if_id_skid_buffer;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, flush = 1'b0;
   logic [31:0] in_instr = '0, in_next_pc = '0, out_instr, out_next_pc;
   logic [1:0] occupancy;
   int vectors = 0, errors = 0;
`ifdef IF_ID_FLUSH_STATS_EN
   logic [15:0] flushed_count;
`endif
   if_id_skid_buffer dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_next_pc(in_next_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_next_pc(out_next_pc),
      .flush(flush), .occupancy(occupancy)
`ifdef IF_ID_FLUSH_STATS_EN
      , .flushed_count(flushed_count)
`endif
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p);
      in_valid = v;
      in_instr = i;
      in_next_pc = p;
   endtask
   localparam logic [31:0] A = 32'h8C220004, B = 32'h00431020, C = 32'hAC230008, NOP = 32'h00000020;
   initial begin
      #12 reset = 1'b1;
      #2;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_occ", occupancy, 0);
      check("rst_instr", out_instr, NOP);
      check("rst_pc", out_next_pc, 0);
      // streaming at full throughput
      out_ready = 1'b1;
      drive(1, A, 32'h4);
      step();
      check("s1_valid", out_valid, 1);
      check("s1_instr", out_instr, A);
      check("s1_pc", out_next_pc, 32'h4);
      check("s1_occ", occupancy, 1);
      drive(1, B, 32'h8);
      step();
      check("s2_instr", out_instr, B);
      check("s2_pc", out_next_pc, 32'h8);
      check("s2_occ", occupancy, 1);
      check("s2_in_ready", in_ready, 1);
      drive(0, 0, 0);
      step();
      check("s3_valid", out_valid, 0);
      check("s3_instr", out_instr, NOP);
      // back-pressure fills the skid entry
      out_ready = 1'b0;
      drive(1, A, 32'h4);
      step();
      check("b1_instr", out_instr, A);
      drive(1, B, 32'h8);
      step();
      check("b2_occ", occupancy, 2);
      check("b2_in_ready", in_ready, 0);
      check("b2_instr", out_instr, A);
      drive(1, C, 32'hC);
      step();
      check("b3_stall_instr", out_instr, A);
      check("b3_stall_pc", out_next_pc, 32'h4);
      check("b3_occ", occupancy, 2);
      out_ready = 1'b1;
      step();
      check("b4_instr", out_instr, B);
      check("b4_pc", out_next_pc, 32'h8);
      check("b4_occ", occupancy, 1);
      check("b4_in_ready", in_ready, 1);
      step();
      check("b5_instr", out_instr, C);
      check("b5_pc", out_next_pc, 32'hC);
      check("b5_occ", occupancy, 1);
      drive(0, 0, 0);
      step();
      check("b6_valid", out_valid, 0);
      check("b6_occ", occupancy, 0);
      // flush with a held word and a same-cycle push
      out_ready = 1'b0;
      drive(1, A, 32'h4);
      step();
      check("f1_occ", occupancy, 1);
      drive(1, B, 32'h8);
      flush = 1'b1;
      step();
      check("f2_occ", occupancy, 0);
      check("f2_valid", out_valid, 0);
      check("f2_instr", out_instr, NOP);
      check("f2_pc", out_next_pc, 0);
`ifdef IF_ID_FLUSH_STATS_EN
      check("f2_count", flushed_count, 2);
`endif
      flush = 1'b0;
      drive(0, 0, 0);
      step();
      check("f3_valid", out_valid, 0);
      check("f3_instr", out_instr, NOP);
      // asynchronous reset from FULL
      drive(1, A, 32'h4);
      step();
      drive(1, B, 32'h8);
      step();
      check("r1_occ", occupancy, 2);
      drive(1, C, 32'hC);
      #2 reset = 1'b0;
      #1;
      check("r2_valid", out_valid, 0);
      check("r2_in_ready", in_ready, 1);
      check("r2_occ", occupancy, 0);
      check("r2_instr", out_instr, NOP);
      step();
      check("r3_occ_in_reset", occupancy, 0);
      check("r3_valid_in_reset", out_valid, 0);
      reset = 1'b1;
      out_ready = 1'b1;
      drive(1, C, 32'hC);
      step();
      check("r4_instr", out_instr, C);
      check("r4_pc", out_next_pc, 32'hC);
      drive(0, 0, 0);
      step();
      check("r5_valid", out_valid, 0);
`ifdef IF_ID_FLUSH_STATS_EN
      // saturation from a preloaded count, two words lost per flush from FULL
      out_ready = 1'b0;
      force dut.flushed_count_q = 16'hFFFC;
      #1 release dut.flushed_count_q;
      for (int k = 0; k < 3; k++) begin
         drive(1, A, 32'h4);
         step();
         drive(1, B, 32'h8);
         step();
         drive(0, 0, 0);
         flush = 1'b1;
         step();
         flush = 1'b0;
         check("sat_count", flushed_count, k == 0 ? 64'hFFFE : 64'hFFFF);
      end
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
